// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_unit_arbiter
// Purpose  : Shares one fixed-latency, fully pipelined floating-point unit
//            between NUM_REQ requesters. A round-robin arbiter issues at most
//            one operand pair per cycle. A tag shift register steers each
//            result back to the requester that issued it, and every returned
//            result is classified as zero, denormal, infinity or NaN.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/a/b       - per-requester operands (packed, W bits each)
//            req_ready           - one-hot grant (combinational)
//            unit_valid/a/b      - issue to the shared unit
//            unit_result         - unit output, UNIT_LATENCY cycles after issue
//            rsp_valid/data/flags- one-hot result strobe, data, {nan,inf,den,zero}
//            busy                - an issued operation has not yet returned
//            grant_count,        - only when FP_ARB_STATS_EN is defined:
//            nan_count             per-requester grant and NaN-result counters
// Options  : FP_ARB_STATS_EN     - adds the statistics counters and ports
// Revision : 1.0 - initial release
// ============================================================================
module fp_unit_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int EXP_BITS     = 8,
    parameter int MANT_BITS    = 23,
    parameter int UNIT_LATENCY = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*(1+EXP_BITS+MANT_BITS)-1:0] req_a,
    input  logic [NUM_REQ*(1+EXP_BITS+MANT_BITS)-1:0] req_b,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  unit_valid,
    output logic [EXP_BITS+MANT_BITS:0]           unit_a,
    output logic [EXP_BITS+MANT_BITS:0]           unit_b,
    input  logic [EXP_BITS+MANT_BITS:0]           unit_result,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [EXP_BITS+MANT_BITS:0]           rsp_data,
    output logic [3:0]                            rsp_flags,
    output logic                                  busy
`ifdef FP_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]                 grant_count,
    output logic [31:0]                           nan_count
`endif
);

    localparam int W     = 1 + EXP_BITS + MANT_BITS;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // Round-robin grant: scan from last_ptr+1, wrapping, first valid wins.
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] r_last_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_found;
    int                 w_scan;

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = (int'(r_last_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[w_scan]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(w_scan);
            end
        end
        // No grant is offered while reset is held.
        if (w_found && !rst) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready  = w_grant;
    assign unit_valid = |(req_valid & w_grant);

    always_comb begin
        unit_a = '0;
        unit_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                unit_a = req_a[i*W +: W];
                unit_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ptr <= c_last_rst;
        end else if (unit_valid) begin
            r_last_ptr <= w_grant_idx;
        end
    end

    // ------------------------------------------------------------------------
    // Tag pipeline: mirrors the unit latency, never stalls.
    // ------------------------------------------------------------------------
    logic [UNIT_LATENCY-1:0] r_tag_valid;
    logic [IDX_W-1:0]        r_tag_idx [UNIT_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid <= '0;
            for (int s = 0; s < UNIT_LATENCY; s++) begin
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_tag_valid[0] <= unit_valid;
            r_tag_idx[0]   <= w_grant_idx;
            for (int s = 1; s < UNIT_LATENCY; s++) begin
                r_tag_valid[s] <= r_tag_valid[s-1];
                r_tag_idx[s]   <= r_tag_idx[s-1];
            end
        end
    end

    assign busy = |r_tag_valid;

    // ------------------------------------------------------------------------
    // Response steering and classification. Gating with rst makes sure a
    // result still sitting in the last stage during the reset cycle is
    // dropped along with everything else in flight.
    // ------------------------------------------------------------------------
    logic                 w_rsp_live;
    logic [EXP_BITS-1:0]  w_exp;
    logic [MANT_BITS-1:0] w_mant;
    logic                 w_exp_zero;
    logic                 w_exp_ones;
    logic                 w_mant_zero;

    assign w_rsp_live = r_tag_valid[UNIT_LATENCY-1] & ~rst;

    always_comb begin
        rsp_valid = '0;
        if (w_rsp_live) begin
            rsp_valid[r_tag_idx[UNIT_LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_data    = w_rsp_live ? unit_result : '0;
    assign w_exp       = rsp_data[MANT_BITS +: EXP_BITS];
    assign w_mant      = rsp_data[MANT_BITS-1:0];
    assign w_exp_zero  = (w_exp == '0);
    assign w_exp_ones  = (w_exp == '1);
    assign w_mant_zero = (w_mant == '0);

    // rsp_data is forced to zero when idle, so the zero flag needs the gate.
    assign rsp_flags = w_rsp_live ?
                       {w_exp_ones & ~w_mant_zero,
                        w_exp_ones &  w_mant_zero,
                        w_exp_zero & ~w_mant_zero,
                        w_exp_zero &  w_mant_zero} : 4'b0000;

`ifdef FP_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics counters, wrapping at 2^32.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        logic [31:0] r_grant_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_grant_cnt <= '0;
            end else if (req_valid[gi] & w_grant[gi]) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
        end
        assign grant_count[gi*32 +: 32] = r_grant_cnt;
    end

    logic [31:0] r_nan_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nan_cnt <= '0;
        end else if (rsp_flags[3]) begin
            r_nan_cnt <= r_nan_cnt + 32'd1;
        end
    end
    assign nan_count = r_nan_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_unit_arbiter
// Purpose  : Self-checking bench for fp_unit_arbiter. A bench-side unit model
//            returns a+b three cycles after issue, or an override value used
//            for the classification sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_unit_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             unit_valid;
    logic [W-1:0]     unit_a;
    logic [W-1:0]     unit_b;
    logic [W-1:0]     unit_result;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic [3:0]       rsp_flags;
    logic             busy;
`ifdef FP_ARB_STATS_EN
    logic [N*32-1:0]  grant_count;
    logic [31:0]      nan_count;
`endif

    fp_unit_arbiter #(
        .NUM_REQ(N), .EXP_BITS(8), .MANT_BITS(23), .UNIT_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .unit_valid(unit_valid), .unit_a(unit_a), .unit_b(unit_b),
        .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .busy(busy)
`ifdef FP_ARB_STATS_EN
        , .grant_count(grant_count), .nan_count(nan_count)
`endif
    );

    always #5 clk = ~clk;

    // Shared unit model: 3-stage pipeline computing a+b.
    logic [W-1:0] pipe [3];
    logic         ovr_en;
    logic [W-1:0] ovr_val;
    always @(posedge clk) begin
        pipe[0] <= unit_valid ? unit_a + unit_b : 32'h0;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign unit_result = ovr_en ? ovr_val : pipe[2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] op_a(input int i);
        return 32'h3F80_0000 + W'(i);
    endfunction
    function automatic logic [W-1:0] op_b(input int i);
        return 32'h0010_0000 + W'(i);
    endfunction

    // Expected operand/sum selected by a one-hot mask (zero when empty).
    function automatic logic [W-1:0] sel_a(input logic [N-1:0] oh);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = op_a(i);
        return r;
    endfunction
    function automatic logic [W-1:0] sel_b(input logic [N-1:0] oh);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = op_b(i);
        return r;
    endfunction

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] rdy;
        logic [N-1:0] rsp;
        logic         bsy;
    } vec_t;

    vec_t tbl [18];

    logic [W-1:0] fvals [4];
    logic [3:0]   fexp  [4];

    initial begin
        // Full contention from reset, then sparse wrap, then back-to-back 0.
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0000, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0100, 4'b0000, 1'b1};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0001, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b0010, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0010, 4'b0100, 1'b1};
        tbl[6]  = '{4'b1111, 4'b0100, 4'b1000, 1'b1};
        tbl[7]  = '{4'b1111, 4'b1000, 4'b0001, 1'b1};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0010, 1'b1};
        tbl[9]  = '{4'b0011, 4'b0001, 4'b0100, 1'b1};
        tbl[10] = '{4'b0011, 4'b0010, 4'b1000, 1'b1};
        tbl[11] = '{4'b0001, 4'b0001, 4'b0100, 1'b1};
        tbl[12] = '{4'b0001, 4'b0001, 4'b0001, 1'b1};
        tbl[13] = '{4'b0001, 4'b0001, 4'b0010, 1'b1};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[16] = '{4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};

        fvals[0] = 32'h7FC0_0000; fexp[0] = 4'b1000;
        fvals[1] = 32'h7F80_0000; fexp[1] = 4'b0100;
        fvals[2] = 32'h0000_0001; fexp[2] = 4'b0010;
        fvals[3] = 32'h0000_0000; fexp[3] = 4'b0001;

        ovr_en = 1'b0;
        ovr_val = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a(i);
            req_b[i*W +: W] = op_b(i);
        end

        // ---------------- single requester ----------------
        do_reset();
        settle();
        chk("idle_ready", W'(req_ready), 32'h0);
        chk("idle_unit_valid", W'(unit_valid), 32'h0);
        chk("idle_rsp_valid", W'(rsp_valid), 32'h0);
        chk("idle_rsp_data", rsp_data, 32'h0);
        chk("idle_flags", W'(rsp_flags), 32'h0);
        chk("idle_busy", W'(busy), 32'h0);
        step();
        req_a[0 +: W] = 32'h3F80_0000;
        req_b[0 +: W] = 32'h4000_0000;
        req_valid = 4'b0001;
        settle();
        chk("single_ready", W'(req_ready), 32'h1);
        chk("single_unit_valid", W'(unit_valid), 32'h1);
        chk("single_unit_a", unit_a, 32'h3F80_0000);
        chk("single_unit_b", unit_b, 32'h4000_0000);
        step();
        req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk("single_busy", W'(busy), (c <= 3) ? 32'h1 : 32'h0);
            chk("single_rsp_valid", W'(rsp_valid), (c == 3) ? 32'h1 : 32'h0);
            chk("single_rsp_data", rsp_data, (c == 3) ? 32'h7F80_0000 : 32'h0);
            chk("single_flags", W'(rsp_flags), (c == 3) ? 32'h4 : 32'h0);
            chk("single_unit_a_idle", unit_a, 32'h0);
            step();
        end
        req_a[0 +: W] = op_a(0);
        req_b[0 +: W] = op_b(0);

        // ---------------- table: contention, wrap, back-to-back ----------------
        do_reset();
        for (int r = 0; r < 18; r++) begin
            req_valid = tbl[r].v;
            settle();
            chk($sformatf("tbl%0d_ready", r), W'(req_ready), W'(tbl[r].rdy));
            chk($sformatf("tbl%0d_unit_valid", r), W'(unit_valid), W'(|tbl[r].rdy));
            chk($sformatf("tbl%0d_unit_a", r), unit_a, sel_a(tbl[r].rdy));
            chk($sformatf("tbl%0d_unit_b", r), unit_b, sel_b(tbl[r].rdy));
            chk($sformatf("tbl%0d_rsp_valid", r), W'(rsp_valid), W'(tbl[r].rsp));
            chk($sformatf("tbl%0d_rsp_data", r), rsp_data,
                sel_a(tbl[r].rsp) + sel_b(tbl[r].rsp));
            chk($sformatf("tbl%0d_flags", r), W'(rsp_flags), 32'h0);
            chk($sformatf("tbl%0d_busy", r), W'(busy), W'(tbl[r].bsy));
            step();
        end

        // ---------------- classification ----------------
        do_reset();
        ovr_en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 4) ? 4'b0001 : 4'b0000;
            ovr_val = (c >= 3) ? fvals[c-3] : 32'h3F80_0000;
            settle();
            if (c >= 3) begin
                chk($sformatf("flags%0d_rsp_valid", c - 3), W'(rsp_valid), 32'h1);
                chk($sformatf("flags%0d_rsp_data", c - 3), rsp_data, fvals[c-3]);
                chk($sformatf("flags%0d_flags", c - 3), W'(rsp_flags), W'(fexp[c-3]));
            end
            step();
        end
        ovr_en = 1'b0;

        // ---------------- reset mid-flight ----------------
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0010;
            settle();
            chk("mid_issue_ready", W'(req_ready), 32'h2);
            step();
        end
        rst = 1'b1;
        req_valid = 4'b1111;
        settle();
        chk("mid_rst_ready", W'(req_ready), 32'h0);
        chk("mid_rst_unit_valid", W'(unit_valid), 32'h0);
        chk("mid_rst_rsp_valid", W'(rsp_valid), 32'h0);
        step();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("mid_drop_rsp_valid", W'(rsp_valid), 32'h0);
            chk("mid_drop_rsp_data", rsp_data, 32'h0);
            chk("mid_drop_busy", W'(busy), 32'h0);
            step();
        end
        req_valid = 4'b1111;
        settle();
        chk("mid_next_grant", W'(req_ready), 32'h1);
        step();
        req_valid = '0;

`ifdef FP_ARB_STATS_EN
        // ---------------- statistics ----------------
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req_valid = 4'b1111;
            step();
        end
        req_valid = '0;
        settle();
        chk("stat_grant3", grant_count[3*32 +: 32], 32'd2);
        chk("stat_grant2", grant_count[2*32 +: 32], 32'd2);
        chk("stat_grant1", grant_count[1*32 +: 32], 32'd3);
        chk("stat_grant0", grant_count[0*32 +: 32], 32'd3);
        for (int c = 0; c < 4; c++) step();
        ovr_en = 1'b1;
        ovr_val = 32'h7FC0_0000;
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 2) ? 4'b0001 : 4'b0000;
            step();
        end
        ovr_en = 1'b0;
        settle();
        chk("stat_nan", nan_count, 32'd2);
        do_reset();
        settle();
        chk("stat_clr_grant", grant_count[31:0] | grant_count[63:32] |
                              grant_count[95:64] | grant_count[127:96], 32'd0);
        chk("stat_clr_nan", nan_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one fixed-latency, fully pipelined floating-point unit (multiplier/adder, IEEE-style sign|exp|mant) between NUM_REQ requesters.
- Round-robin issue: at most one operand pair per cycle. A tag shift register routes each result back to its originator exactly UNIT_LATENCY cycles after issue.
- Classifies every returned result (zero/denorm/inf/NaN) so PEs need no local decode logic.
- Sits between the TPU PE-group request ports and the shared FP unit instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- EXP_BITS, 8, exponent field width.
- MANT_BITS, 23, mantissa field width; operand width W = 1+EXP_BITS+MANT_BITS.
- UNIT_LATENCY, 3, cycles from unit_valid to the corresponding unit_result (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand-valid.
- req_a  input  NUM_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  input  NUM_REQ*W  operand B, same packing.
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- unit_valid  output  1  issue strobe to the shared unit.
- unit_a  output  W  operand A to the unit.
- unit_b  output  W  operand B to the unit.
- unit_result  input  W  unit output, valid exactly UNIT_LATENCY cycles after the unit_valid that produced it.
- rsp_valid  output  NUM_REQ  one-hot result strobe, single cycle, no backpressure.
- rsp_data  output  W  result, shared by all requesters.
- rsp_flags  output  4  {is_nan, is_inf, is_denorm, is_zero} of rsp_data.
- busy  output  1  high while any issued operation has not yet returned.

Behaviour:
- Grant (combinational):
  - Scan req_valid starting at index (last_ptr+1) mod NUM_REQ, wrapping around. The first asserted index gets req_ready.
  - req_ready is all zeros when req_valid is all zeros, and while rst is high.
  - req_ready never depends on unit_result.
- Issue (combinational):
  - unit_valid = |(req_valid & req_ready).
  - unit_a/unit_b = granted requester's operands; zero when unit_valid is low.
- last_ptr:
  - Register, updated to the granted index on each transfer.
  - Holds otherwise; reset value NUM_REQ-1, so index 0 wins first.
- Tag pipeline:
  - Register array of UNIT_LATENCY stages, each {valid, idx[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {unit_valid, granted idx}; the array shifts every cycle; there are no stalls.
- Response (combinational from last tag stage):
  - rsp_valid[idx] = last stage valid.
  - rsp_data = unit_result when last stage valid, else 0.
  - rsp_flags are computed from rsp_data fields:
    - is_zero: exp==0 & mant==0.
    - is_denorm: exp==0 & mant!=0.
    - is_inf: exp==all-ones & mant==0.
    - is_nan: exp==all-ones & mant!=0.
    - All flags are 0 when rsp_valid is 0.
- Throughput and latency:
  - One issue per cycle; a single requester may hold valid and be granted every cycle when uncontended.
  - Under full contention each requester gets 1 grant every NUM_REQ cycles.
  - Issue at edge t produces rsp_valid in the cycle after edge t+UNIT_LATENCY-1, i.e. exactly UNIT_LATENCY cycles later.
- busy: OR of all tag-stage valid bits (registered state only).
- Simultaneous issue and return in one cycle are independent; both occur.
- Reset:
  - Synchronous; clears all tag valids and sets last_ptr = NUM_REQ-1.
  - In-flight results are dropped: no rsp_valid for any operation issued before reset, even though the unit may still emit data.
  - After reset deasserts, outputs are: req_ready 0 (until req_valid), unit_valid 0, rsp_valid 0, rsp_data 0, rsp_flags 0, busy 0.
- Requesters must hold operands stable while req_valid is high and not granted. Dropping req_valid before grant is permitted (no transfer).

Optional Feature:
- Macro FP_ARB_STATS_EN.
- When defined:
  - Adds output grant_count (NUM_REQ*32): per-requester 32-bit counters, +1 per transfer, wrapping at 2^32.
  - Adds output nan_count (32): +1 per returned result with is_nan.
  - All counters clear on rst.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester: rst low, req_valid=4'b0001, a=0x3F800000, b=0x40000000 for 1 cycle -> req_ready=0001 same cycle; unit_a/b match; rsp_valid=0001 exactly 3 cycles later with rsp_data=unit_result; busy high for 3 cycles.
- Full contention: req_valid=1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rsp_valid order identical, one per cycle, starting 3 cycles after first grant.
- Sparse round-robin wrap: last grant=2, req_valid=0011 -> grants 0 then 1 (wrap skips 3). Back-to-back requester 0 alone -> granted every cycle.
- Flags: bench unit returns 0x7FC00000, 0x7F800000, 0x00000001, 0x00000000 on successive responses -> rsp_flags 1000, 0100, 0010, 0001.
- Reset mid-flight: issue 3 ops on consecutive cycles, assert rst 1 cycle after the last -> no rsp_valid ever for those ops, busy=0, next grant goes to requester 0.
- FP_ARB_STATS_EN: 10 contended cycles with 1111 -> grant_count = {2,2,3,3} (index 3 first); 2 NaN results -> nan_count=2; rst clears all to 0.
